// File: rtl/lynx_tap_loader_if.sv
// Download-bus and RAM-port bundle for the Lynx .TAP loader.
// The master side feeds ioctl bytes and observes the tape write port.
interface lynx_tap_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] tape_addr;
    logic        tape_wr;
    logic [7:0]  tape_dout;
    logic        tape_complete;
    logic        tape_error;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  tape_addr, tape_wr, tape_dout, tape_complete, tape_error
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output tape_addr, tape_wr, tape_dout, tape_complete, tape_error
    );
endinterface

// File: rtl/lynx_tap_loader.sv
// Parses a streamed Lynx machine-code .TAP image, writes its payload into RAM
// and reports the execution address with a one-cycle completion pulse.
module lynx_tap_loader #(
    parameter int         NAME_MAX  = 16,
    parameter logic [7:0] TYPE_CHAR = 8'h4D
) (
    input logic              clock,
    input logic              reset,
    lynx_tap_loader_if.slave bus
);
    localparam int NCW = $clog2(NAME_MAX + 1);

    typedef enum logic [3:0] {
        IDLE, Q_OPEN, NAME, TYPE, LEN_L, LEN_H, LOAD_L, LOAD_H,
        DATA, EXEC_L, EXEC_H, WAIT_END, ERROR
    } state_t;

    state_t         state, state_n, cur;
    logic [NCW-1:0] name_cnt, name_cnt_n;
    logic [15:0]    len, len_n, load, load_n, exec_addr, exec_n, idx, idx_n;
    logic [15:0]    addr_r, addr_n;
    logic [7:0]     dout_r, dout_n;
    logic           wr_r, wr_n, cmp_r, cmp_n, err_r;
    logic           dl_d, rise, fall, wr_en, restart;
    logic [7:0]     b;

    assign rise    = bus.ioctl_download & ~dl_d;
    assign fall    = ~bus.ioctl_download & dl_d;
    // A strobe landing in the same cycle as the download fall is still consumed.
    assign wr_en   = bus.ioctl_wr & (bus.ioctl_download | fall);
    assign restart = rise | (wr_en & (bus.ioctl_addr == '0));
    assign b       = bus.ioctl_dout;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dl_d      <= 1'b0;
            name_cnt  <= '0;
            len       <= '0;
            load      <= '0;
            exec_addr <= '0;
            idx       <= '0;
            addr_r    <= '0;
            dout_r    <= '0;
            wr_r      <= 1'b0;
            cmp_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state     <= state_n;
            dl_d      <= bus.ioctl_download;
            name_cnt  <= name_cnt_n;
            len       <= len_n;
            load      <= load_n;
            exec_addr <= exec_n;
            idx       <= idx_n;
            addr_r    <= addr_n;
            dout_r    <= dout_n;
            wr_r      <= wr_n;
            cmp_r     <= cmp_n;
            err_r     <= (state_n == ERROR);
        end
    end

    always_comb begin
        cur        = state;
        name_cnt_n = name_cnt;
        len_n      = len;
        load_n     = load;
        exec_n     = exec_addr;
        idx_n      = idx;
        addr_n     = addr_r;
        dout_n     = dout_r;
        wr_n       = 1'b0;
        cmp_n      = 1'b0;

        if (restart) begin
            cur        = Q_OPEN;
            name_cnt_n = '0;
            idx_n      = '0;
        end
        state_n = cur;

        if (wr_en) begin
            case (cur)
                Q_OPEN: state_n = (b == 8'h22) ? NAME : ERROR;
                NAME: begin
                    if (b == 8'h22)                       state_n = TYPE;
                    else if (name_cnt == NCW'(NAME_MAX))  state_n = ERROR;
                    else                                  name_cnt_n = name_cnt + NCW'(1);
                end
                TYPE:   state_n = (b == TYPE_CHAR) ? LEN_L : ERROR;
                LEN_L: begin len_n = {len[15:8], b};  state_n = LEN_H;  end
                LEN_H: begin len_n = {b, len[7:0]};   state_n = LOAD_L; end
                LOAD_L: begin load_n = {load[15:8], b}; state_n = LOAD_H; end
                LOAD_H: begin
                    load_n  = {b, load[7:0]};
                    idx_n   = '0;
                    state_n = (len == 16'd0) ? EXEC_L : DATA;
                end
                DATA: begin
                    wr_n   = 1'b1;
                    dout_n = b;
                    addr_n = load + idx;
                    idx_n  = idx + 16'd1;
                    if (idx == len - 16'd1) state_n = EXEC_L;
                end
                EXEC_L: begin exec_n = {exec_addr[15:8], b}; state_n = EXEC_H;   end
                EXEC_H: begin exec_n = {b, exec_addr[7:0]};  state_n = WAIT_END; end
                default: state_n = cur;
            endcase
        end

        // Evaluated after the byte so a final EXEC_H write still completes.
        if (fall) begin
            if (state_n == WAIT_END) begin
                state_n = IDLE;
                cmp_n   = 1'b1;
                addr_n  = exec_n;
            end else if (state_n != IDLE && state_n != ERROR) begin
                state_n = ERROR;
            end
        end
    end

    assign bus.tape_addr     = addr_r;
    assign bus.tape_wr       = wr_r;
    assign bus.tape_dout     = dout_r;
    assign bus.tape_complete = cmp_r;
    assign bus.tape_error    = err_r;
endmodule

// File: tb/tb_lynx_tap_loader.sv
// Bench for lynx_tap_loader: directed table, corner sequences and random
// images checked against a byte-level parse model of the .TAP format.
module tb_lynx_tap_loader;
    localparam int NAME_MAX = 16;
    localparam logic [7:0] TYPE_CHAR = 8'h4D;

    typedef logic [7:0]  byte_q[$];
    typedef logic [23:0] wq_t[$];

    typedef struct {
        int          nl;
        logic [7:0]  ty;
        logic [15:0] len;
        logic [15:0] load;
        logic [7:0]  d0;
        logic [15:0] ex;
        int          cut;
        int          exp_nwr;
        int          exp_cmp;
        int          exp_err;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0, errors = 0;
    wq_t  wr_q;
    int   n_cmp = 0, both = 0;
    logic [15:0] cmp_addr = '0;

    lynx_tap_loader_if bus();

    lynx_tap_loader #(.NAME_MAX(NAME_MAX), .TYPE_CHAR(TYPE_CHAR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset) begin
            if (bus.tape_wr) wr_q.push_back({bus.tape_addr, bus.tape_dout});
            if (bus.tape_complete) begin n_cmp++; cmp_addr = bus.tape_addr; end
            if (bus.tape_wr && bus.tape_complete) both++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic byte_q mk(input int nl, input logic [7:0] ty, input logic [15:0] len,
                                 input logic [15:0] load, input logic [7:0] d0,
                                 input logic [15:0] ex, input int cut, input int trail);
        byte_q q;
        q.push_back(8'h22);
        for (int k = 0; k < nl; k++) q.push_back(8'(8'h41 + k));
        q.push_back(8'h22);
        q.push_back(ty);
        q.push_back(len[7:0]);  q.push_back(len[15:8]);
        q.push_back(load[7:0]); q.push_back(load[15:8]);
        for (int k = 0; k < int'(len); k++) q.push_back(8'(d0 + 8'h11 * k));
        q.push_back(ex[7:0]); q.push_back(ex[15:8]);
        for (int k = 0; k < cut; k++) void'(q.pop_back());
        for (int k = 0; k < trail; k++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Reference: parse the whole image as a file, then assume download drops.
    task automatic model(input byte_q q, output wq_t ew, output bit ec,
                         output logic [15:0] ex, output bit ee);
        int n, i, p, len;
        logic [15:0] load;
        ew = {}; ec = 0; ex = '0; ee = 1;
        n = q.size();
        if (n < 1 || q[0] != 8'h22) return;
        i = 1;
        while (i < n && q[i] != 8'h22) begin
            if (i - 1 >= NAME_MAX) return;
            i++;
        end
        if (i + 6 > n) return;
        if (q[i+1] != TYPE_CHAR) return;
        len  = int'({q[i+3], q[i+2]});
        load = {q[i+5], q[i+4]};
        p = i + 6;
        for (int k = 0; k < len; k++) begin
            if (p + k >= n) return;
            ew.push_back({16'(load + 16'(k)), q[p+k]});
        end
        p += len;
        if (p + 2 > n) return;
        ee = 0; ec = 1; ex = {q[p+1], q[p]};
    endtask

    task automatic send(input int a, input logic [7:0] d);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'(a);
        bus.ioctl_dout = d;
        @(negedge clock);
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic run_image(input byte_q img, input bit gaps);
        wr_q.delete(); n_cmp = 0;
        @(negedge clock); bus.ioctl_download = 1'b1;
        @(negedge clock);
        foreach (img[i]) begin
            send(i, img[i]);
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        repeat (2) @(negedge clock);
        bus.ioctl_download = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic compare(input string tag, input byte_q img);
        wq_t ew; bit ec; logic [15:0] ex; bit ee;
        model(img, ew, ec, ex, ee);
        chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(ew.size()));
        foreach (ew[k]) if (k < wr_q.size()) chk({tag, "_wr"}, 32'(wr_q[k]), 32'(ew[k]));
        chk({tag, "_cmp"}, 32'(n_cmp), 32'(ec));
        if (ec) begin
            chk({tag, "_exec"}, 32'(cmp_addr), 32'(ex));
            chk({tag, "_hold"}, 32'(bus.tape_addr), 32'(ex));
        end
        chk({tag, "_err"}, 32'(bus.tape_error), 32'(ee));
    endtask

    vec_t  vt[7];
    byte_q img;

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;

        vt[0] = '{2,  8'h4D, 16'd3, 16'h6000, 8'h11, 16'h6010, 0, 3, 1, 0};
        vt[1] = '{2,  8'h4D, 16'd2, 16'hFFFF, 8'hAA, 16'h1357, 0, 2, 1, 0};
        vt[2] = '{0,  8'h4D, 16'd0, 16'h8000, 8'h00, 16'h1234, 0, 0, 1, 0};
        vt[3] = '{2,  8'h42, 16'd3, 16'h6000, 8'h11, 16'h6010, 0, 0, 0, 1};
        vt[4] = '{16, 8'h4D, 16'd1, 16'h3000, 8'h5A, 16'h3003, 0, 1, 1, 0};
        vt[5] = '{2,  8'h4D, 16'd3, 16'h6000, 8'h11, 16'h6010, 3, 2, 0, 1};
        vt[6] = '{17, 8'h4D, 16'd1, 16'h3000, 8'h5A, 16'h3003, 0, 0, 0, 1};

        #12;
        chk("rst_addr", 32'(bus.tape_addr), 32'h0);
        chk("rst_wr", 32'(bus.tape_wr), 32'h0);
        chk("rst_dout", 32'(bus.tape_dout), 32'h0);
        chk("rst_cmp", 32'(bus.tape_complete), 32'h0);
        chk("rst_err", 32'(bus.tape_error), 32'h0);
        @(negedge clock); reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            img = mk(vt[i].nl, vt[i].ty, vt[i].len, vt[i].load, vt[i].d0, vt[i].ex, vt[i].cut, 0);
            run_image(img, 1'b0);
            chk("vec_nwr", 32'(wr_q.size()), 32'(vt[i].exp_nwr));
            chk("vec_cmp", 32'(n_cmp), 32'(vt[i].exp_cmp));
            chk("vec_err", 32'(bus.tape_error), 32'(vt[i].exp_err));
            if (vt[i].exp_cmp != 0) chk("vec_exec", 32'(cmp_addr), 32'(vt[i].ex));
            compare("vec", img);
        end

        // Async reset in the middle of the payload.
        img = mk(1, 8'h4D, 16'd5, 16'h4000, 8'h51, 16'h4444, 0, 0);
        wr_q.delete();
        @(negedge clock); bus.ioctl_download = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 10; i++) send(i, img[i]);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(bus.tape_addr), 32'h0);
        chk("mid_rst_wr", 32'(bus.tape_wr), 32'h0);
        chk("mid_rst_dout", 32'(bus.tape_dout), 32'h0);
        chk("mid_rst_err", 32'(bus.tape_error), 32'h0);
        @(negedge clock); bus.ioctl_download = 1'b0; reset = 1'b1;
        @(negedge clock);
        img = mk(3, 8'h4D, 16'd4, 16'h5000, 8'h0F, 16'h5123, 0, 0);
        run_image(img, 1'b0);
        compare("rst_reload", img);

        // Error recovery through an ioctl_addr=0 write without dropping download.
        wr_q.delete(); n_cmp = 0;
        @(negedge clock); bus.ioctl_download = 1'b1;
        @(negedge clock);
        send(0, 8'h22); send(1, 8'h22); send(2, 8'h42);
        @(negedge clock);
        chk("bad_type_err", 32'(bus.tape_error), 32'h1);
        img = mk(0, 8'h4D, 16'd1, 16'h2000, 8'h77, 16'h2ABC, 0, 2);
        foreach (img[i]) send(i, img[i]);
        @(negedge clock);
        bus.ioctl_download = 1'b0;
        repeat (3) @(negedge clock);
        compare("restart0", img);

        // Sticky error survives the fall, cleared by the next rising edge.
        img = mk(1, 8'h42, 16'd1, 16'h2000, 8'h77, 16'h2ABC, 0, 0);
        run_image(img, 1'b0);
        chk("sticky_err", 32'(bus.tape_error), 32'h1);
        bus.ioctl_download = 1'b1;
        repeat (2) @(negedge clock);
        chk("rise_clr_err", 32'(bus.tape_error), 32'h0);
        bus.ioctl_download = 1'b0;
        repeat (3) @(negedge clock);

        for (int r = 0; r < 40; r++) begin
            int nl, cut, trail;
            logic [7:0] ty;
            logic [15:0] len, load;
            nl    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 18)) : int'($urandom_range(0, 5));
            ty    = ($urandom_range(0, 9) == 0) ? 8'h42 : TYPE_CHAR;
            len   = 16'($urandom_range(0, 6));
            load  = ($urandom_range(0, 2) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
            cut   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            trail = (cut == 0) ? int'($urandom_range(0, 3)) : 0;
            img = mk(nl, ty, len, load, 8'($urandom), 16'($urandom), cut, trail);
            run_image(img, 1'b1);
            compare("rand", img);
        end

        chk("wr_cmp_excl", 32'(both), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
